// File: rtl/divider_arbiter_pkg.sv
// Shared constants, state encoding and word-split helpers for the divider arbiter.
package divider_arbiter_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned OPND_W = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_A_HI = 3'd1,
    SEND_A_LO = 3'd2,
    SEND_B_HI = 3'd3,
    SEND_B_LO = 3'd4,
    GET_Z_HI  = 3'd5,
    GET_Z_LO  = 3'd6,
    PUT_RES   = 3'd7
  } state_e;

  // Upper half of an operand, sent to the divider first.
  function automatic logic [WORD_W-1:0] hi_word(input logic [OPND_W-1:0] v);
    return v[OPND_W-1 -: WORD_W];
  endfunction

  // Lower half of an operand, sent second.
  function automatic logic [WORD_W-1:0] lo_word(input logic [OPND_W-1:0] v);
    return v[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/divider_arbiter_rr_grant2.sv
// Two-way grant: a lone requester always wins; on contention the requester not
// served last wins in round-robin mode, requester 0 wins in fixed-priority mode.
module rr_grant2 #(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // One-hot grant from the request pair and the last-served pointer.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01: grant_o = 2'b01;
      2'b10: grant_o = 2'b10;
      2'b11: begin
        if ((ROUND_ROBIN != 32'd0) && (last_i == 1'b0)) begin
          grant_o = 2'b10;
        end else begin
          grant_o = 2'b01;
        end
      end
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one 16-bit-word divider between two 32-bit requesters. One operation
// is in flight at a time: operands go out high word first, the quotient comes
// back high word first and is handed, unmodified, to the owning requester.
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPND_W-1:0] req0_a,
  input  logic [OPND_W-1:0] req0_b,
  input  logic              req0_stb,
  output logic              req0_ack,
  output logic [OPND_W-1:0] res0_z,
  output logic              res0_stb,
  input  logic              res0_ack,
  input  logic [OPND_W-1:0] req1_a,
  input  logic [OPND_W-1:0] req1_b,
  input  logic              req1_stb,
  output logic              req1_ack,
  output logic [OPND_W-1:0] res1_z,
  output logic              res1_stb,
  input  logic              res1_ack,
  output logic [WORD_W-1:0] div_a,
  output logic              div_a_stb,
  input  logic              div_a_ack,
  output logic [WORD_W-1:0] div_b,
  output logic              div_b_stb,
  input  logic              div_b_ack,
  input  logic [WORD_W-1:0] div_z,
  input  logic              div_z_stb,
  output logic              div_z_ack,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [OPND_W-1:0] a_q, a_d;
  logic [OPND_W-1:0] b_q, b_d;
  logic [OPND_W-1:0] z_q, z_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [1:0]        grant_s;

  rr_grant2 #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_grant (
    .req_i  ({req1_stb, req0_stb}),
    .last_i (last_q),
    .grant_o(grant_s)
  );

  // State and datapath registers; last-served starts at 1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next state, register updates and handshake outputs for the current state.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    z_d       = z_q;
    owner_d   = owner_q;
    last_d    = last_q;
    req0_ack  = 1'b0;
    req1_ack  = 1'b0;
    res0_stb  = 1'b0;
    res1_stb  = 1'b0;
    res0_z    = z_q;
    res1_z    = z_q;
    div_a     = '0;
    div_a_stb = 1'b0;
    div_b     = '0;
    div_b_stb = 1'b0;
    div_z_ack = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        req0_ack = grant_s[0];
        req1_ack = grant_s[1];
        if (grant_s[1]) begin
          a_d     = req1_a;
          b_d     = req1_b;
          owner_d = 1'b1;
          state_d = SEND_A_HI;
        end else if (grant_s[0]) begin
          a_d     = req0_a;
          b_d     = req0_b;
          owner_d = 1'b0;
          state_d = SEND_A_HI;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_A_HI: begin
        div_a     = hi_word(a_q);
        div_a_stb = 1'b1;
        state_d   = div_a_ack ? SEND_A_LO : SEND_A_HI;
      end
      SEND_A_LO: begin
        div_a     = lo_word(a_q);
        div_a_stb = 1'b1;
        state_d   = div_a_ack ? SEND_B_HI : SEND_A_LO;
      end
      SEND_B_HI: begin
        div_b     = hi_word(b_q);
        div_b_stb = 1'b1;
        state_d   = div_b_ack ? SEND_B_LO : SEND_B_HI;
      end
      SEND_B_LO: begin
        div_b     = lo_word(b_q);
        div_b_stb = 1'b1;
        state_d   = div_b_ack ? GET_Z_HI : SEND_B_LO;
      end
      GET_Z_HI: begin
        div_z_ack = 1'b1;
        if (div_z_stb) begin
          z_d     = {div_z, lo_word(z_q)};
          state_d = GET_Z_LO;
        end else begin
          state_d = GET_Z_HI;
        end
      end
      GET_Z_LO: begin
        div_z_ack = 1'b1;
        if (div_z_stb) begin
          z_d     = {hi_word(z_q), div_z};
          state_d = PUT_RES;
        end else begin
          state_d = GET_Z_LO;
        end
      end
      PUT_RES: begin
        res0_stb = ~owner_q;
        res1_stb = owner_q;
        if (owner_q ? res1_ack : res0_ack) begin
          last_d  = owner_q;
          state_d = IDLE;
        end else begin
          state_d = PUT_RES;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Two arbiters (round-robin and fixed priority) each driven by random requesters
// and a behavioural word-serial divider; a monitor per instance checks grants,
// divider word order and delivered quotients against queues filled at issue time.
module tb_divider_arbiter;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic        rst_m  [2];
  logic        hold_m [2][2];
  op_t         pend_q [2][2][$];
  logic [31:0] expz_q [2][2][$];
  logic [15:0] expw_q [2][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no event want event", name);
  endtask

  // IEEE single <-> real via double bit patterns (normals, zero, inf).
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) d = {x[31], 63'd0};
    else if (x[30:23] == 8'hFF) d = {x[31], 11'h7FF, x[22:0], 29'd0};
    else d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int          ee;
    d  = $realtobits(r);
    ee = int'(d[62:52]) - 896;
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
    if (ee >= 255) return {d[63], 8'hFF, 23'd0};
    if (ee <= 0) return {d[63], 31'd0};
    return {d[63], ee[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    return r2sp(sp2r(a) / sp2r(b));
  endfunction

  // Divisor is a power of two, so the quotient is exact.
  function automatic op_t rand_op();
    op_t o;
    o.a = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
    o.b = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'd0};
    o.z = fdiv(o.a, o.b);
    return o;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : env
    localparam bit RR = (g == 0);
    logic [31:0] req0_a, req0_b, req1_a, req1_b, res0_z, res1_z;
    logic        req0_stb, req0_ack, req1_stb, req1_ack;
    logic        res0_stb, res0_ack, res1_stb, res1_ack;
    logic [15:0] div_a, div_b, div_z;
    logic        div_a_stb, div_a_ack, div_b_stb, div_b_ack, div_z_stb, div_z_ack;
    logic        busy;
    int          wcnt;

    divider_arbiter #(.ROUND_ROBIN(RR ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst_m[g]),
      .req0_a(req0_a), .req0_b(req0_b), .req0_stb(req0_stb), .req0_ack(req0_ack),
      .res0_z(res0_z), .res0_stb(res0_stb), .res0_ack(res0_ack),
      .req1_a(req1_a), .req1_b(req1_b), .req1_stb(req1_stb), .req1_ack(req1_ack),
      .res1_z(res1_z), .res1_stb(res1_stb), .res1_ack(res1_ack),
      .div_a(div_a), .div_a_stb(div_a_stb), .div_a_ack(div_a_ack),
      .div_b(div_b), .div_b_stb(div_b_stb), .div_b_ack(div_b_ack),
      .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack),
      .busy(busy)
    );

    // Requesters, result takers and a word-serial divider with random ack delay.
    initial begin
      int          phase, cnt;
      logic [15:0] w [4];
      logic [15:0] da, db;
      logic [31:0] zr;
      logic        acc0, acc1, xa, xb, xz;
      op_t         op;
      req0_a = 32'd0; req0_b = 32'd0; req0_stb = 1'b0; res0_ack = 1'b0;
      req1_a = 32'd0; req1_b = 32'd0; req1_stb = 1'b0; res1_ack = 1'b0;
      div_a_ack = 1'b0; div_b_ack = 1'b0; div_z = 16'd0; div_z_stb = 1'b0;
      phase = 0; cnt = 0; zr = 32'd0;
      forever begin
        @(negedge clk);
        acc0 = req0_stb & req0_ack;
        acc1 = req1_stb & req1_ack;
        xa   = div_a_stb & div_a_ack;
        xb   = div_b_stb & div_b_ack;
        xz   = div_z_stb & div_z_ack;
        da   = div_a;
        db   = div_b;
        @(posedge clk);
        #1;
        if (rst_m[g]) begin
          req0_stb = 1'b0; req1_stb = 1'b0; res0_ack = 1'b0; res1_ack = 1'b0;
          pend_q[g][0].delete(); pend_q[g][1].delete();
          div_a_ack = 1'b0; div_b_ack = 1'b0; div_z_stb = 1'b0;
          phase = 0; cnt = 0;
        end else begin
          if (acc0) req0_stb = 1'b0;
          if (!req0_stb && pend_q[g][0].size() > 0) begin
            op = pend_q[g][0].pop_front();
            req0_a = op.a; req0_b = op.b; req0_stb = 1'b1;
            expz_q[g][0].push_back(op.z);
          end
          if (acc1) req1_stb = 1'b0;
          if (!req1_stb && pend_q[g][1].size() > 0) begin
            op = pend_q[g][1].pop_front();
            req1_a = op.a; req1_b = op.b; req1_stb = 1'b1;
            expz_q[g][1].push_back(op.z);
          end
          if (phase < 4) begin
            if (xa || xb) begin
              w[phase] = xa ? da : db;
              phase++;
              div_a_ack = 1'b0; div_b_ack = 1'b0;
              cnt = $urandom_range(0, 5);
            end else if ((phase < 2 && div_a_stb) || (phase >= 2 && div_b_stb)) begin
              if (cnt == 0) begin
                if (phase < 2) div_a_ack = 1'b1;
                else div_b_ack = 1'b1;
              end else begin
                cnt--;
              end
            end
            if (phase == 4) begin
              zr = fdiv({w[0], w[1]}, {w[2], w[3]});
              div_z = zr[31:16];
              div_z_stb = 1'b1;
            end
          end else if (xz) begin
            if (phase == 4) begin
              div_z = zr[15:0];
              phase = 5;
            end else begin
              div_z_stb = 1'b0;
              phase = 0;
            end
          end
          res0_ack = !hold_m[g][0] && ($urandom_range(0, 2) != 0);
          res1_ack = !hold_m[g][1] && ($urandom_range(0, 2) != 0);
        end
      end
    end

    // Monitor: grant rule, divider word order, result ownership/stability/value.
    initial begin
      logic        r_edge, inflight, owner, last;
      logic [1:0]  s, ea;
      logic        rs [2], rk [2], pv [2];
      logic [31:0] rz [2], pz [2];
      inflight = 1'b0; owner = 1'b0; last = 1'b1; wcnt = 0;
      pv[0] = 1'b0; pv[1] = 1'b0; pz[0] = 32'd0; pz[1] = 32'd0;
      forever begin
        @(posedge clk);
        r_edge = rst_m[g];
        @(negedge clk);
        if (r_edge) begin
          chk("reset_outputs", {24'd0, busy, req0_ack, req1_ack, res0_stb, res1_stb,
                                div_a_stb, div_b_stb, div_z_ack}, 32'd0);
          expz_q[g][0].delete(); expz_q[g][1].delete(); expw_q[g].delete();
          inflight = 1'b0; last = 1'b1; wcnt = 0; pv[0] = 1'b0; pv[1] = 1'b0;
        end else begin
          chk("busy", {31'd0, busy}, {31'd0, inflight});
          if (!inflight)
            chk("idle_quiet", {27'd0, div_a_stb, div_b_stb, div_z_ack, res0_stb, res1_stb}, 32'd0);
          s  = {req1_stb, req0_stb};
          ea = 2'b00;
          if (!inflight) begin
            if (s == 2'b11) ea = (RR && last == 1'b0) ? 2'b10 : 2'b01;
            else ea = s;
          end
          chk("req_ack", {30'd0, req1_ack, req0_ack}, {30'd0, ea});
          if (div_a_stb && div_a_ack) begin
            if (expw_q[g].size() == 0) fail("div_a_extra");
            else chk("div_a_word", {16'd0, div_a}, {16'd0, expw_q[g].pop_front()});
            wcnt++;
          end
          if (div_b_stb && div_b_ack) begin
            if (expw_q[g].size() == 0) fail("div_b_extra");
            else chk("div_b_word", {16'd0, div_b}, {16'd0, expw_q[g].pop_front()});
            wcnt++;
          end
          rs[0] = res0_stb; rk[0] = res0_ack; rz[0] = res0_z;
          rs[1] = res1_stb; rk[1] = res1_ack; rz[1] = res1_z;
          for (int r = 0; r < 2; r++) begin
            if (rs[r]) begin
              chk("res_owner", {30'd0, inflight, owner}, {30'd0, 1'b1, 1'(r)});
              if (pv[r]) chk("res_hold", rz[r], pz[r]);
              if (rk[r]) begin
                if (expz_q[g][r].size() == 0) fail("res_unexpected");
                else chk("res_z", rz[r], expz_q[g][r].pop_front());
                inflight = 1'b0;
                last = 1'(r);
              end
            end
            pv[r] = rs[r] && !rk[r];
            pz[r] = rz[r];
          end
          if (ea != 2'b00) begin
            owner = ea[1];
            inflight = 1'b1;
            wcnt = 0;
            if (ea[1]) begin
              expw_q[g].push_back(req1_a[31:16]); expw_q[g].push_back(req1_a[15:0]);
              expw_q[g].push_back(req1_b[31:16]); expw_q[g].push_back(req1_b[15:0]);
            end else begin
              expw_q[g].push_back(req0_a[31:16]); expw_q[g].push_back(req0_a[15:0]);
              expw_q[g].push_back(req0_b[31:16]); expw_q[g].push_back(req0_b[15:0]);
            end
          end
        end
      end
    end
  end

  task automatic push_op(input int i, input int r, input op_t o);
    pend_q[i][r].push_back(o);
  endtask

  task automatic push_both(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] z);
    op_t o;
    o.a = a; o.b = b; o.z = z;
    push_op(0, r, o);
    push_op(1, r, o);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_m[0] = 1'b1; rst_m[1] = 1'b1;
    @(negedge clk); #2;
    rst_m[0] = 1'b0; rst_m[1] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 8000 && !done; c++) begin
      @(negedge clk); #2;
      done = 1'b1;
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < 2; r++)
          if (pend_q[i][r].size() != 0 || expz_q[i][r].size() != 0) done = 1'b0;
      if (env[0].busy || env[1].busy) done = 1'b0;
    end
    if (!done) fail(name);
  endtask

  // Reset instance i while it is sending the low divisor word.
  task automatic reset_mid(input int i);
    bit hit;
    hit = 1'b0;
    push_op(i, 0, rand_op());
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge clk); #2;
      if (i == 0) hit = (env[0].wcnt == 3) && env[0].div_b_stb;
      else hit = (env[1].wcnt == 3) && env[1].div_b_stb;
    end
    if (!hit) fail("reach_send_b_lo");
    rst_m[i] = 1'b1;
    @(negedge clk); #2;
    rst_m[i] = 1'b0;
  endtask

  initial begin
    bit seen;
    rst_m[0] = 1'b1; rst_m[1] = 1'b1;
    hold_m[0][0] = 1'b0; hold_m[0][1] = 1'b0; hold_m[1][0] = 1'b0; hold_m[1][1] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_m[0] = 1'b0; rst_m[1] = 1'b0;

    // Single requester, directed operands.
    push_both(0, 32'h40C00000, 32'h40000000, 32'h40400000);
    wait_drain("drain_single");

    // Both requesters together right after reset.
    do_reset();
    push_both(0, 32'h3F800000, 32'h40800000, 32'h3E800000);
    push_both(1, 32'h41200000, 32'h40A00000, 32'h40000000);
    wait_drain("drain_both");

    // Back-to-back requests held high from both sides.
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 2; i++) begin
        push_op(i, 0, rand_op());
        push_op(i, 1, rand_op());
      end
    wait_drain("drain_b2b");

    // Result held back for 20 cycles while requester 1 waits.
    do_reset();
    hold_m[0][0] = 1'b1; hold_m[1][0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_op(i, 0, rand_op());
      push_op(i, 1, rand_op());
    end
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk); #2;
      seen = env[0].res0_stb && env[1].res0_stb;
    end
    if (!seen) fail("res0_stb_rise");
    repeat (20) @(negedge clk);
    #2;
    hold_m[0][0] = 1'b0; hold_m[1][0] = 1'b0;
    wait_drain("drain_hold");

    // Reset mid-operation, then a fresh 1.0/0.0 from requester 1.
    reset_mid(0);
    wait_drain("drain_after_rst0");
    reset_mid(1);
    push_both(1, 32'h3F800000, 32'h00000000, 32'h7F800000);
    wait_drain("drain_after_rst1");

    // Random traffic with random gaps.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < 2; r++)
          if ($urandom_range(0, 1) == 1) push_op(i, r, rand_op());
      repeat ($urandom_range(0, 30)) @(negedge clk);
      #2;
    end
    wait_drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 SHALL have parameter: ROUND_ROBIN, 1, 1 = round-robin between requesters, 0 = fixed priority to requester 0.
REQ-002 SHALL have a single clock and a synchronous, active-high reset; ports clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req0_a, req0_b  input  32  requester 0 dividend and divisor, IEEE-754 single.
REQ-006 req0_stb  input  1  requester 0 operands valid; req0_ack  output  1  operands accepted.
REQ-007 res0_z  output  32  requester 0 quotient; res0_stb  output  1  result valid; res0_ack  input  1  result taken.
REQ-008 req1_a, req1_b, req1_stb, req1_ack, res1_z, res1_stb, res1_ack: same as REQ-005..007 for requester 1.
REQ-009 div_a  output  16  divider operand-A word; div_a_stb  output  1; div_a_ack  input  1.
REQ-010 div_b  output  16  divider operand-B word; div_b_stb  output  1; div_b_ack  input  1.
REQ-011 div_z  input  16  divider result word; div_z_stb  input  1; div_z_ack  output  1.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 A transfer SHALL occur on a rising edge where both stb and ack are high; stb, once raised, stays high and data stays stable until the transfer.
REQ-014 The FSM SHALL use states IDLE, SEND_A_HI, SEND_A_LO, SEND_B_HI, SEND_B_LO, GET_Z_HI, GET_Z_LO, PUT_RES, advancing in that order, one step per completed transfer.
REQ-015 In IDLE, reqN_ack SHALL be driven combinationally high only for the winner among requesters with reqN_stb high; with no stb, both acks low.
REQ-016 Arbitration SHALL give priority, when both stb are high, to the requester not last served (ROUND_ROBIN=1) or always to requester 0 (ROUND_ROBIN=0).
REQ-017 On acceptance, a, b and owner index SHALL be registered and the FSM SHALL enter SEND_A_HI; div_a_stb rises the next cycle.
REQ-018 Words SHALL be sent high half first: div_a = a[31:16] then a[15:0], then div_b = b[31:16] then b[15:0].
REQ-019 In GET_Z_HI and GET_Z_LO, div_z_ack SHALL be high; div_z is captured into z[31:16] then z[15:0] on each transfer.
REQ-020 In PUT_RES, resN_stb SHALL be high for the owner only, with resN_z = z held stable; on resN_ack the FSM returns to IDLE and the last-served pointer is set to the owner.
REQ-021 Only one operation SHALL be outstanding; a requester with a pending result is not re-accepted until IDLE.
REQ-022 A request whose stb is high while another is in flight SHALL wait (no ack) and be served at the next IDLE.
REQ-023 No stb/ack output SHALL be high outside the states named in REQ-015..020.
REQ-024 Result data SHALL be passed unmodified; no arithmetic is performed on operands or quotient.

Reset
REQ-025 On rst: state IDLE; req0_ack, req1_ack, res0_stb, res1_stb, div_a_stb, div_b_stb, div_z_ack, busy all 0; last-served pointer = requester 1 (so requester 0 wins first).
REQ-026 Reset mid-operation SHALL abandon the transaction without delivering a result; rst SHALL be shared with the divider so both restart together.

Structure
REQ-027 State encodings, word width 16, and operand width 32 SHALL be constants in the shared fpu package.
REQ-028 The two-way grant logic SHALL be a sub-module rr_grant2 (inputs: two requests, last-served pointer, ROUND_ROBIN; output: one-hot grant).

Verification
REQ-029 req0 a=0x40C00000, b=0x40000000 alone -> div words 0x40C0,0x0000,0x4000,0x0000 in order; res0_z=0x40400000; res1_stb never high.
REQ-030 Both stb high after reset: req0 0x3F800000/0x40800000, req1 0x41200000/0x40A00000 -> req0 served first (0x3E800000), then req1 (0x40000000).
REQ-031 Back-to-back requests from both, held high, ROUND_ROBIN=1 -> grants alternate 0,1,0,1; ROUND_ROBIN=0 -> requester 0 always wins while its stb is high.
REQ-032 res0_ack held low 20 cycles -> res0_stb and res0_z stable; req1 receives no ack throughout.
REQ-033 rst asserted in SEND_B_LO -> next cycle all stb/ack outputs 0, busy 0; fresh req1 1.0/0.0 -> res1_z=0x7F800000.
REQ-034 Divider acks delayed randomly 0-5 cycles -> word order and result unchanged; no word transferred twice.
